perf_event_collector: RTL and testbench
=======================================

# perf_event_collector

Hardware performance-event collector that sits downstream of the per-module performance event sources. It accumulates up to EVENT_NUM multi-count event strobes per cycle into wide counters. On request it takes an atomic snapshot of all counters and streams it out as (id, value, overflow) beats over a valid/ready handshake to the debug/difftest readout path. Counting continues undisturbed while the snapshot drains.

## Interface
Parameters:
- EVENT_NUM, 16, number of event channels (≥2)
- EVENT_WIDTH, 3, per-cycle increment width per channel (multi-issue events add 0..2^EVENT_WIDTH-1)
- CNT_WIDTH, 48, counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  global count enable; increments ignored when low
- event_inc  in  EVENT_NUM×EVENT_WIDTH  per-channel increment this cycle
- clear  in  1  synchronous clear of all live counters and overflow flags
- dump_req  in  1  request snapshot + readout; accepted only when dump_busy low
- dump_busy  out  1  high while in STREAM
- out_valid  out  1  readout beat valid
- out_ready  in  1  consumer ready
- out_id  out  $clog2(EVENT_NUM)  channel index of current beat
- out_value  out  CNT_WIDTH  snapshotted counter value
- out_ovf  out  1  snapshotted overflow flag
- dump_done  out  1  one-cycle pulse after final beat handshake

## Operation
- Live counter i: if clear → 0 and ovf_i → 0 (clear wins over same-cycle increment); else if en → cnt_i + event_inc[i] (zero-extended); else hold.
- Overflow: see Configuration; ovf_i sticky until clear.
- FSM states IDLE, STREAM.
  - IDLE: dump_req=1 → copy all live cnt/ovf (pre-increment register values at that edge) into shadow arrays, idx←0, go STREAM.
  - STREAM: out_valid=1, out_id=idx, out_value/out_ovf=shadow[idx]. On out_valid&&out_ready: if idx==EVENT_NUM-1 → IDLE, pulse dump_done next cycle; else idx+1.
- dump_req while STREAM: ignored (not queued).
- clear during STREAM: live counters clear; shadow untouched.
- out_ready held low: beat held stable, no timeout.
- Async reset mid-stream: immediate return to IDLE, all state zero; no dump_done.

## Timing
- Reset values: dump_busy=0, out_valid=0, out_id=0, out_value=0, out_ovf=0, dump_done=0; all counters, ovf flags, shadows, idx = 0.
- Event in cycle T visible in live counter at T+1.
- dump_req accepted at edge T → out_valid/dump_busy high from T+1, first beat id 0.
- Max throughput one beat/cycle; full dump ≥ EVENT_NUM cycles.
- Last handshake at edge T → dump_busy=0 and dump_done=1 in T+1; dump_req in T+1 accepted (new snapshot at edge T+1).
- All outputs registered; out_value driven from shadow mux indexed by registered idx.

## Configuration
- PERF_SATURATE_EN defined: counter saturates at 2^CNT_WIDTH-1; ovf_i set when sum would exceed max; stays at max until clear.
- Undefined: counter wraps modulo 2^CNT_WIDTH; ovf_i set on carry-out; value keeps counting.

## Structure
- Package perf_pkg: perf_state_t enum (IDLE, STREAM), default EVENT_NUM/EVENT_WIDTH/CNT_WIDTH constants.
- Sub-module perf_counter: one live counter + ovf flag with clear/en/inc, saturate/wrap selected by PERF_SATURATE_EN; instantiated EVENT_NUM times via generate. FSM, shadow array and readout mux in top.

## Test plan
- Reset, en=1, event_inc[3]=5 for 4 cycles, dump_req → beat id 3 value 20, all other ids value 0, ovf 0; dump_done one cycle after beat 15.
- CNT_WIDTH=8, channel 0 inc 7 for 40 cycles: without macro value 280 mod 256=24 ovf=1; with PERF_SATURATE_EN value 255 ovf=1.
- clear and event_inc[1]=4 same cycle → counter 1 stays 0; next cycle inc 4 → 4.
- dump_req, out_ready toggling 1/0 every cycle, events continue → 16 beats ids 0..15 in order, values equal snapshot at accept edge, stable while ready low; second dump_req mid-stream ignored.
- Last handshake then dump_req in dump_done cycle → new STREAM starts next cycle with refreshed snapshot.
- rst asserted during beat 7 → out_valid/dump_busy drop immediately, counters 0, no dump_done.

Source files
------------

// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the performance-event collector:
//   - default channel count, per-cycle increment width and counter width
//   - readout FSM state encoding
// Build option: PERF_SATURATE_EN (see perf_counter) selects saturating counters.
// -----------------------------------------------------------------------------
package perf_pkg;

  localparam int unsigned PERF_EVENT_NUM   = 16;
  localparam int unsigned PERF_EVENT_WIDTH = 3;
  localparam int unsigned PERF_CNT_WIDTH   = 48;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } perf_state_t;

endpackage : perf_pkg

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// One live event counter with a sticky overflow flag.
//   clk, rst  : clock, asynchronous active-low reset
//   clear_i   : synchronous clear of counter and flag (wins over increment)
//   en_i      : count enable
//   inc_i     : increment for this cycle (zero-extended into the counter)
//   cnt_o     : current counter value (registered)
//   ovf_o     : sticky overflow flag (registered)
// Build option PERF_SATURATE_EN: when defined the counter sticks at its
// maximum value once the sum would exceed it; otherwise it wraps and the
// flag records the carry-out.
// -----------------------------------------------------------------------------
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned EVENT_WIDTH = PERF_EVENT_WIDTH,
  parameter int unsigned CNT_WIDTH   = PERF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [EVENT_WIDTH-1:0] inc_i,
  output logic [CNT_WIDTH-1:0]   cnt_o,
  output logic                   ovf_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [CNT_WIDTH:0]   sum_s;

  // One extra bit keeps the carry-out for overflow detection.
  assign sum_s = {1'b0, cnt_q} + {{(CNT_WIDTH + 1 - EVENT_WIDTH){1'b0}}, inc_i};

  // Next-state: clear has priority, then enabled accumulate, else hold.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = {CNT_WIDTH{1'b0}};
      ovf_d = 1'b0;
    end else if (en_i) begin
`ifdef PERF_SATURATE_EN
      if (sum_s[CNT_WIDTH]) begin
        cnt_d = {CNT_WIDTH{1'b1}};
        ovf_d = 1'b1;
      end else begin
        cnt_d = sum_s[CNT_WIDTH-1:0];
        ovf_d = ovf_q;
      end
`else
      cnt_d = sum_s[CNT_WIDTH-1:0];
      ovf_d = ovf_q | sum_s[CNT_WIDTH];
`endif
    end else begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
    end
  end

  // Counter and overflow flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule : perf_counter

// File: rtl/perf_event_collector.sv
// -----------------------------------------------------------------------------
// perf_event_collector
// Accumulates EVENT_NUM multi-count event strobes into wide live counters and,
// on request, streams an atomic snapshot of every counter out as
// (id, value, overflow) beats over a valid/ready handshake. Live counting is
// not disturbed while the snapshot drains.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   en          : global count enable
//   event_inc   : packed per-channel increments, channel i at [i*EVENT_WIDTH +: EVENT_WIDTH]
//   clear       : synchronous clear of live counters and overflow flags
//   dump_req    : snapshot + readout request, taken only while idle
//   dump_busy   : readout in progress
//   out_valid   : readout beat valid
//   out_ready   : consumer ready
//   out_id      : channel index of the current beat
//   out_value   : snapshotted counter value
//   out_ovf     : snapshotted overflow flag
//   dump_done   : one-cycle pulse after the final beat handshake
// Build option: PERF_SATURATE_EN selects saturating instead of wrapping counters.
// -----------------------------------------------------------------------------
module perf_event_collector
  import perf_pkg::*;
#(
  parameter int unsigned EVENT_NUM   = PERF_EVENT_NUM,
  parameter int unsigned EVENT_WIDTH = PERF_EVENT_WIDTH,
  parameter int unsigned CNT_WIDTH   = PERF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [EVENT_NUM*EVENT_WIDTH-1:0] event_inc,
  input  logic                             clear,
  input  logic                             dump_req,
  output logic                             dump_busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(EVENT_NUM)-1:0]     out_id,
  output logic [CNT_WIDTH-1:0]             out_value,
  output logic                             out_ovf,
  output logic                             dump_done
);

  localparam int unsigned     ID_W    = $clog2(EVENT_NUM);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(EVENT_NUM - 1);

  logic [CNT_WIDTH-1:0] live_cnt_s   [EVENT_NUM];
  logic [EVENT_NUM-1:0] live_ovf_s;
  logic [CNT_WIDTH-1:0] shadow_cnt_q [EVENT_NUM];
  logic [EVENT_NUM-1:0] shadow_ovf_q;

  perf_state_t          state_q;
  perf_state_t          state_d;
  logic [ID_W-1:0]      idx_q;
  logic [ID_W-1:0]      idx_d;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] value_q;
  logic [CNT_WIDTH-1:0] value_d;
  logic                 vovf_q;
  logic                 vovf_d;
  logic                 done_q;
  logic                 accept_s;
  logic                 fire_s;
  logic                 last_s;

  // Live counters, one per channel.
  for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cnt
    perf_counter #(
      .EVENT_WIDTH (EVENT_WIDTH),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear),
      .en_i    (en),
      .inc_i   (event_inc[g*EVENT_WIDTH +: EVENT_WIDTH]),
      .cnt_o   (live_cnt_s[g]),
      .ovf_o   (live_ovf_s[g])
    );
  end

  assign accept_s = (state_q == IDLE) && dump_req;
  assign fire_s   = (state_q == STREAM) && out_ready;
  assign last_s   = fire_s && (idx_q == LAST_ID);

  // Readout FSM next state and beat index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = STREAM;
          idx_d   = {ID_W{1'b0}};
        end else begin
          state_d = IDLE;
          idx_d   = idx_q;
        end
      end
      STREAM: begin
        if (last_s) begin
          state_d = IDLE;
          idx_d   = {ID_W{1'b0}};
        end else if (fire_s) begin
          state_d = STREAM;
          idx_d   = idx_q + ID_W'(1);
        end else begin
          state_d = STREAM;
          idx_d   = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {ID_W{1'b0}};
      end
    endcase
  end

  // Next beat payload. On the accept edge the shadow is being written in the
  // same cycle, so beat 0 is taken straight from the live counter.
  always_comb begin
    value_d = {CNT_WIDTH{1'b0}};
    vovf_d  = 1'b0;
    if (accept_s) begin
      value_d = live_cnt_s[0];
      vovf_d  = live_ovf_s[0];
    end else if (state_d == STREAM) begin
      value_d = shadow_cnt_q[idx_d];
      vovf_d  = shadow_ovf_q[idx_d];
    end else begin
      value_d = {CNT_WIDTH{1'b0}};
      vovf_d  = 1'b0;
    end
  end

  // FSM and registered readout outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= {ID_W{1'b0}};
      busy_q  <= 1'b0;
      value_q <= {CNT_WIDTH{1'b0}};
      vovf_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == STREAM);
      value_q <= value_d;
      vovf_q  <= vovf_d;
      done_q  <= last_s;
    end
  end

  // Snapshot capture: pre-increment live values at the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < EVENT_NUM; i++) begin
        shadow_cnt_q[i] <= {CNT_WIDTH{1'b0}};
      end
      shadow_ovf_q <= {EVENT_NUM{1'b0}};
    end else if (accept_s) begin
      for (int i = 0; i < EVENT_NUM; i++) begin
        shadow_cnt_q[i] <= live_cnt_s[i];
      end
      shadow_ovf_q <= live_ovf_s;
    end else begin
      shadow_ovf_q <= shadow_ovf_q;
    end
  end

  assign dump_busy = busy_q;
  assign out_valid = busy_q;
  assign out_id    = idx_q;
  assign out_value = value_q;
  assign out_ovf   = vovf_q;
  assign dump_done = done_q;

endmodule : perf_event_collector

// File: tb/tb_perf_event_collector.sv
// -----------------------------------------------------------------------------
// tb_perf_event_collector
// Self-checking bench: a reference model of the live counters and readout FSM
// pushes the expected beats of every snapshot into a scoreboard queue at the
// accept edge; the beats presented by the DUT are compared against the queue
// head each cycle and popped on handshake. A second, narrow instance
// (CNT_WIDTH=8) exercises wrap/saturate behaviour (PERF_SATURATE_EN).
// -----------------------------------------------------------------------------
module tb_perf_event_collector;

  localparam int NUM = 16;
  localparam int EW  = 3;
  localparam int CW  = 48;

  typedef struct {
    logic [3:0]    id;
    logic [CW-1:0] val;
    logic          ovf;
  } beat_t;

  logic            clk;
  logic            rst;
  logic            en;
  logic [NUM*EW-1:0] event_inc;
  logic            clear;
  logic            dump_req;
  logic            dump_busy;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_id;
  logic [CW-1:0]   out_value;
  logic            out_ovf;
  logic            dump_done;

  logic            s_en;
  logic [5:0]      s_inc;
  logic            s_clear;
  logic            s_dump_req;
  logic            s_busy;
  logic            s_valid;
  logic            s_ready;
  logic [0:0]      s_id;
  logic [7:0]      s_value;
  logic            s_ovf;
  logic            s_done;

  int              errors;
  int              checks;

  logic [CW-1:0]   mc [NUM];
  logic            mo [NUM];
  logic            m_busy;
  logic            m_done;
  int              m_idx;
  beat_t           sb [$];

  perf_event_collector #(
    .EVENT_NUM   (NUM),
    .EVENT_WIDTH (EW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .event_inc (event_inc),
    .clear     (clear),
    .dump_req  (dump_req),
    .dump_busy (dump_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_value (out_value),
    .out_ovf   (out_ovf),
    .dump_done (dump_done)
  );

  perf_event_collector #(
    .EVENT_NUM   (2),
    .EVENT_WIDTH (3),
    .CNT_WIDTH   (8)
  ) dut_small (
    .clk       (clk),
    .rst       (rst),
    .en        (s_en),
    .event_inc (s_inc),
    .clear     (s_clear),
    .dump_req  (s_dump_req),
    .dump_busy (s_busy),
    .out_valid (s_valid),
    .out_ready (s_ready),
    .out_id    (s_id),
    .out_value (s_value),
    .out_ovf   (s_ovf),
    .dump_done (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      mc[i] = '0;
      mo[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
    sb.delete();
  endtask

  // Check the DUT against the model, predict the next edge, advance one clock.
  task automatic tick();
    beat_t       exp;
    beat_t       nb;
    logic        acc;
    logic        hs;
    logic        last;
    logic [CW:0] s;
    checks++;
    if (dump_busy !== m_busy) begin
      errors++;
      $display("FAIL busy: got %0b want %0b at %0t", dump_busy, m_busy, $time);
    end
    checks++;
    if (out_valid !== m_busy) begin
      errors++;
      $display("FAIL valid: got %0b want %0b at %0t", out_valid, m_busy, $time);
    end
    checks++;
    if (dump_done !== m_done) begin
      errors++;
      $display("FAIL done: got %0b want %0b at %0t", dump_done, m_done, $time);
    end
    if (m_busy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: beat presented with no expectation at %0t", $time);
      end else begin
        exp = sb[0];
        if (out_id !== exp.id || out_value !== exp.val || out_ovf !== exp.ovf) begin
          errors++;
          $display("FAIL beat: got id=%0d val=%0d ovf=%0b want id=%0d val=%0d ovf=%0b at %0t",
                   out_id, out_value, out_ovf, exp.id, exp.val, exp.ovf, $time);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
    hs   = m_busy && out_ready;
    last = hs && (m_idx == NUM - 1);
    acc  = !m_busy && dump_req;
    if (acc) begin
      for (int i = 0; i < NUM; i++) begin
        nb.id  = 4'(i);
        nb.val = mc[i];
        nb.ovf = mo[i];
        sb.push_back(nb);
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (clear) begin
        mc[i] = '0;
        mo[i] = 1'b0;
      end else if (en) begin
        s = {1'b0, mc[i]} + (CW+1)'(event_inc[i*EW +: EW]);
`ifdef PERF_SATURATE_EN
        if (s[CW]) begin
          mc[i] = '1;
          mo[i] = 1'b1;
        end else begin
          mc[i] = s[CW-1:0];
        end
`else
        mc[i] = s[CW-1:0];
        mo[i] = mo[i] | s[CW];
`endif
      end
    end
    m_done = last;
    if (acc) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (hs) begin
      if (last) m_busy = 1'b0;
      else m_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound && m_busy; k++) tick();
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b after %0d cycles, want 0", m_busy, bound);
    end
  endtask

  // Request a dump, drain it with ready high, spot-check one channel value.
  task automatic run_dump(input int chk_id, input logic [CW-1:0] chk_val);
    logic [3:0] cid;
    cid = 4'(chk_id);
    dump_req = 1'b1;
    tick();
    dump_req  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 64 && m_busy; k++) begin
      if (out_valid && out_id == cid) begin
        checks++;
        if (out_value !== chk_val) begin
          errors++;
          $display("FAIL chan_value: id=%0d got %0d want %0d", cid, out_value, chk_val);
        end
      end
      tick();
    end
    wait_idle(1);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (dump_busy !== 1'b0 || out_valid !== 1'b0 || out_id !== 4'd0 ||
        out_value !== 48'd0 || out_ovf !== 1'b0 || dump_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b valid=%0b id=%0d val=%0d ovf=%0b done=%0b want all 0",
               dump_busy, out_valid, out_id, out_value, out_ovf, dump_done);
    end
    checks++;
    if (s_valid !== 1'b0 || s_value !== 8'd0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_small: valid=%0b val=%0d done=%0b want 0",
               s_valid, s_value, s_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_basic();
    en = 1'b1;
    event_inc = '0;
    event_inc[3*EW +: EW] = 3'd5;
    for (int k = 0; k < 4; k++) tick();
    event_inc = '0;
    run_dump(3, 48'd20);
  endtask

  task automatic test_clear();
    clear = 1'b1;
    event_inc = '0;
    event_inc[1*EW +: EW] = 3'd4;
    tick();
    clear = 1'b0;
    tick();
    event_inc = '0;
    run_dump(1, 48'd4);
  endtask

  task automatic test_overflow();
    en = 1'b0;
    s_en = 1'b1;
    s_inc = 6'd7;
    for (int k = 0; k < 40; k++) tick();
    s_en = 1'b0;
    s_inc = 6'd0;
    s_dump_req = 1'b1;
    tick();
    s_dump_req = 1'b0;
    s_ready = 1'b1;
    checks++;
`ifdef PERF_SATURATE_EN
    if (s_valid !== 1'b1 || s_id !== 1'b0 || s_value !== 8'd255 || s_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sat: valid=%0b id=%0d val=%0d ovf=%0b want 1 0 255 1",
               s_valid, s_id, s_value, s_ovf);
    end
`else
    if (s_valid !== 1'b1 || s_id !== 1'b0 || s_value !== 8'd24 || s_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_wrap: valid=%0b id=%0d val=%0d ovf=%0b want 1 0 24 1",
               s_valid, s_id, s_value, s_ovf);
    end
`endif
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_id !== 1'b1 || s_value !== 8'd0 || s_ovf !== 1'b0) begin
      errors++;
      $display("FAIL overflow_ch1: valid=%0b id=%0d val=%0d ovf=%0b want 1 1 0 0",
               s_valid, s_id, s_value, s_ovf);
    end
    tick();
    checks++;
    if (s_done !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_done: done=%0b busy=%0b want 1 0", s_done, s_busy);
    end
    s_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int k;
    en = 1'b1;
    k = 0;
    while (k < 100 && (k < 2 || m_busy)) begin
      event_inc = {16'($urandom), 32'($urandom)};
      dump_req  = (k == 0) || (k == 8);
      clear     = (k == 12);
      out_ready = (k % 2 == 1);
      tick();
      k++;
    end
    dump_req = 1'b0;
    clear    = 1'b0;
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL backpressure_timeout: still busy after %0d cycles, want idle", k);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    event_inc = {16'($urandom), 32'($urandom)};
    dump_req = 1'b1;
    tick();
    dump_req  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && m_busy; k++) begin
      event_inc = {16'($urandom), 32'($urandom)};
      tick();
    end
    wait_idle(1);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 40 && m_busy; k++) begin
      event_inc = {16'($urandom), 32'($urandom)};
      tick();
    end
    wait_idle(1);
    event_inc = '0;
    tick();
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    event_inc = {16'($urandom), 32'($urandom)};
    dump_req = 1'b1;
    tick();
    dump_req  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && !(m_busy && m_idx == 7); k++) tick();
    checks++;
    if (!(m_busy && m_idx == 7) || out_id !== 4'd7) begin
      errors++;
      $display("FAIL reach_beat7: id=%0d want 7", out_id);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dump_busy !== 1'b0 || out_id !== 4'd0 || dump_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b busy=%0b id=%0d done=%0b want 0 0 0 0",
               out_valid, dump_busy, out_id, dump_done);
    end
    en = 1'b0;
    event_inc = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    run_dump(3, 48'd0);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b0;
    en         = 1'b0;
    event_inc  = '0;
    clear      = 1'b0;
    dump_req   = 1'b0;
    out_ready  = 1'b0;
    s_en       = 1'b0;
    s_inc      = 6'd0;
    s_clear    = 1'b0;
    s_dump_req = 1'b0;
    s_ready    = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_clear();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_perf_event_collector
